rr_arbiter_16: RTL and testbench
================================

Name: rr_arbiter_16

Overview:
- 16-requester round-robin arbiter producing a registered 4-bit grant index, with a valid/ready handshake.
- Sits directly upstream of the team's 4-to-16 decoder; the decoder turns grant_idx into one-hot channel enables.
- Guarantees fair, starvation-free servicing of up to 16 requesters, at up to one grant per clock.

Parameters:
- RESET_PTR, 4'd0, priority pointer value after reset (first index searched).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  16  request vector; bit i = requester i wants service.
- out_ready  input  1  downstream accepts the current grant this cycle.
- grant_valid  output  1  grant_idx holds a valid grant.
- grant_idx  output  4  index of the granted requester.
- busy  output  1  high while in the GRANT state (equals grant_valid).

Behaviour:
- Reset (async, rst_n=0):
  - grant_valid=0, grant_idx=4'd0, busy=0.
  - Priority pointer ptr=RESET_PTR; state=IDLE.
- All outputs are registered. There is no combinational path from req or out_ready to any output.
- Selection function sel(ptr, req): the first set bit of req searching ptr, ptr+1, ..., 15, 0, ..., ptr-1, with mod-16 wrap.
- State IDLE:
  - If req!=0: grant_idx<=sel(ptr,req), grant_valid<=1, go to GRANT.
  - Otherwise stay in IDLE.
  - Latency: req seen at edge N gives grant_valid=1 after edge N, i.e. visible in cycle N+1.
- State GRANT:
  - grant_idx and grant_valid hold stable until a handshake (grant_valid & out_ready).
  - Grant is sticky: deasserting req[grant_idx] mid-grant does not revoke or change the grant.
- On a handshake:
  - ptr<=grant_idx+1, with 4'd15 wrapping to 4'd0.
  - If req!=0 in that same cycle: grant_idx<=sel(grant_idx+1, req), grant_valid stays 1, stay in GRANT. This gives back-to-back grants at 1 per cycle.
  - If req==0: grant_valid<=0, go to IDLE. grant_idx keeps its last value (don't-care while invalid).
- Simultaneous events:
  - A requester that was just served and still requests is eligible again.
  - It is searched last, because ptr has advanced past it.
- Single active requester: the same index may be granted on consecutive handshakes.
- Fairness bound: any continuously asserted requester is granted within 16 handshakes.
- ptr updates only on a handshake; it never changes while waiting for out_ready.
- Reset mid-grant: everything returns to reset values immediately. An outstanding grant is discarded and not replayed.
- X-safety: req bits are only examined via the search. The default/illegal state path returns to IDLE with grant_valid=0.

Test Plan:
- Reset then req=16'h0001, out_ready=1 -> one cycle later grant_valid=1, grant_idx=0. Next cycle (req still set) grant_idx=0 again with grant_valid held; ptr=1.
- req=16'h8421 held, out_ready=1 -> grant_idx sequence 0,5,10,15,0,... back-to-back with no valid gaps.
- req=16'h0030, out_ready=0 for 5 cycles -> grant_idx=4 stable, grant_valid=1 throughout. Raise out_ready -> next grant is 5.
- Wrap: ptr=15 (prior grant 14), req=16'h8001 -> grant 15, then 0, then 15.
- Grant idx 3 pending; req drops to 0 -> grant_valid stays 1 until out_ready. After the handshake, grant_valid=0 and state is IDLE.
- rst_n pulsed low mid-GRANT with grant_idx=9 -> grant_valid=0 and grant_idx=0 asynchronously. After release, req=16'h0200 yields grant_idx=9 searched from RESET_PTR.

Source files
------------

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with a registered 4-bit grant index and a valid/ready handshake.
// A grant stays stable until accepted; the priority pointer moves just past each accepted grant.
module rr_arbiter_16 #(
  parameter logic [3:0] RESET_PTR = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        out_ready,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } state_t;

  state_t      r_state;
  logic [3:0]  r_ptr;
  logic [3:0]  r_idx;
  logic        r_valid;
  logic        r_busy;
  logic [3:0]  w_next_ptr;
  logic        w_handshake;

  // First set bit of r, searching upward from p with mod-16 wrap.
  function automatic logic [3:0] sel(input logic [3:0] p, input logic [15:0] r);
    logic [3:0] s;
    logic [3:0] w;
    logic       found;
    s     = p;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      w = p + 4'(i);
      if (!found && r[w]) begin
        found = 1'b1;
        s     = w;
      end
    end
    return s;
  endfunction

  assign w_next_ptr  = r_idx + 4'd1;
  assign w_handshake = r_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= RESET_PTR;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req != '0) begin
            r_idx   <= sel(r_ptr, req);
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_handshake) begin
            r_ptr <= w_next_ptr;
            if (req != '0) begin
              r_idx <= sel(w_next_ptr, req);
            end else begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign grant_valid = r_valid;
  assign grant_idx   = r_idx;
  assign busy        = r_busy;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: a behavioural model predicts each cycle's grant into a
// scoreboard queue, and each scenario task pops and compares against the DUT and literal expectations.
module tb_rr_arbiter_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        out_ready;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [3:0] idx;
  } exp_t;

  typedef struct {
    logic [15:0] r;
    logic        rdy;
    logic        v;
    logic [3:0]  idx;
  } stim_t;

  exp_t q_exp[$];

  logic       m_valid;
  logic [3:0] m_idx;
  logic [3:0] m_ptr;

  rr_arbiter_16 #(.RESET_PTR(4'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .out_ready   (out_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate the request vector so that index p lands at bit 0, then take the lowest set bit.
  function automatic logic [3:0] msel(input logic [3:0] p, input logic [15:0] r);
    logic [31:0] d;
    logic [3:0]  k;
    d = {r, r} >> p;
    k = 4'd0;
    for (int j = 15; j >= 0; j--)
      if (d[j]) k = 4'(j);
    return p + k;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 4'd0;
    m_ptr   = 4'd0;
    q_exp.delete();
  endtask

  task automatic drive(input logic [15:0] r, input logic rdy);
    exp_t e;
    e.v   = m_valid;
    e.idx = m_idx;
    if (!m_valid) begin
      if (r != 16'h0) begin
        e.v   = 1'b1;
        e.idx = msel(m_ptr, r);
      end
    end else if (rdy) begin
      m_ptr = m_idx + 4'd1;
      if (r != 16'h0) e.idx = msel(m_ptr, r);
      else            e.v   = 1'b0;
    end
    q_exp.push_back(e);
    req       = r;
    out_ready = rdy;
    @(posedge clk);
    #1;
    m_valid = e.v;
    m_idx   = e.idx;
  endtask

  task automatic do_reset();
    req       = 16'h0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Runs a stimulus table; each step is compared against the scoreboard and the literal expectation.
  task automatic run_table(input string name, input stim_t t[$]);
    exp_t e;
    foreach (t[k]) begin
      drive(t[k].r, t[k].rdy);
      e = q_exp.pop_front();
      checks++;
      if (grant_valid !== e.v || busy !== e.v || (e.v && grant_idx !== e.idx)) begin
        errors++;
        $display("FAIL %s_sb step %0d: got valid=%b busy=%b idx=%0d, want valid=%b idx=%0d",
                 name, k, grant_valid, busy, grant_idx, e.v, e.idx);
      end
      checks++;
      if (grant_valid !== t[k].v || (t[k].v && grant_idx !== t[k].idx)) begin
        errors++;
        $display("FAIL %s_lit step %0d: got valid=%b idx=%0d, want valid=%b idx=%0d",
                 name, k, grant_valid, grant_idx, t[k].v, t[k].idx);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: got valid=%b idx=%0d busy=%b, want 0 0 0", grant_valid, grant_idx, busy);
    end
  endtask

  task automatic test_single();
    stim_t t[$];
    do_reset();
    t = '{'{16'h0001, 1'b1, 1'b1, 4'd0},
          '{16'h0001, 1'b1, 1'b1, 4'd0},
          '{16'h0001, 1'b1, 1'b1, 4'd0},
          '{16'h0000, 1'b1, 1'b0, 4'd0}};
    run_table("single", t);
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    do_reset();
    t = '{'{16'h8421, 1'b1, 1'b1, 4'd0},
          '{16'h8421, 1'b1, 1'b1, 4'd5},
          '{16'h8421, 1'b1, 1'b1, 4'd10},
          '{16'h8421, 1'b1, 1'b1, 4'd15},
          '{16'h8421, 1'b1, 1'b1, 4'd0},
          '{16'h8421, 1'b1, 1'b1, 4'd5},
          '{16'h0000, 1'b1, 1'b0, 4'd0}};
    run_table("b2b", t);
  endtask

  task automatic test_hold();
    stim_t t[$];
    do_reset();
    t = '{'{16'h0030, 1'b0, 1'b1, 4'd4},
          '{16'h0030, 1'b0, 1'b1, 4'd4},
          '{16'h0030, 1'b0, 1'b1, 4'd4},
          '{16'h0030, 1'b0, 1'b1, 4'd4},
          '{16'h0030, 1'b0, 1'b1, 4'd4},
          '{16'h0030, 1'b1, 1'b1, 4'd5},
          '{16'h0000, 1'b1, 1'b0, 4'd0}};
    run_table("hold", t);
  endtask

  task automatic test_wrap();
    stim_t t[$];
    do_reset();
    t = '{'{16'h4000, 1'b1, 1'b1, 4'd14},
          '{16'h8001, 1'b1, 1'b1, 4'd15},
          '{16'h8001, 1'b1, 1'b1, 4'd0},
          '{16'h8001, 1'b1, 1'b1, 4'd15},
          '{16'h0000, 1'b1, 1'b0, 4'd0}};
    run_table("wrap", t);
  endtask

  task automatic test_sticky();
    stim_t t[$];
    do_reset();
    t = '{'{16'h0008, 1'b0, 1'b1, 4'd3},
          '{16'h0000, 1'b0, 1'b1, 4'd3},
          '{16'h0000, 1'b0, 1'b1, 4'd3},
          '{16'h0010, 1'b0, 1'b1, 4'd3},
          '{16'h0000, 1'b1, 1'b0, 4'd0},
          '{16'h0000, 1'b0, 1'b0, 4'd0}};
    run_table("sticky", t);
  endtask

  task automatic test_reset_mid();
    stim_t t[$];
    do_reset();
    t = '{'{16'h0200, 1'b0, 1'b1, 4'd9},
          '{16'h0300, 1'b0, 1'b1, 4'd9}};
    run_table("pre_rst", t);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got valid=%b idx=%0d busy=%b, want 0 0 0", grant_valid, grant_idx, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    t = '{'{16'h0200, 1'b1, 1'b1, 4'd9},
          '{16'h0000, 1'b1, 1'b0, 4'd0}};
    run_table("post_rst", t);
  endtask

  task automatic test_random();
    exp_t        e;
    logic [15:0] r;
    logic        rdy;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r   = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      drive(r, rdy);
      e = q_exp.pop_front();
      checks++;
      if (grant_valid !== e.v || busy !== e.v || (e.v && grant_idx !== e.idx)) begin
        errors++;
        $display("FAIL random step %0d: got valid=%b busy=%b idx=%0d, want valid=%b idx=%0d",
                 k, grant_valid, busy, grant_idx, e.v, e.idx);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 16'h0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_wrap();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
